// File: rtl/lpddr5_refresh_ctrl_pkg.sv
// Shared LPDDR5 timing defaults and refresh scheduler types.
// Build option: LPDDR5_REF_POSTPONE_EN enables refresh postponing.
package lpddr5_refresh_ctrl_pkg;

  localparam int tREFI = 100;
  localparam int tRFC  = 20;
  localparam int tRP   = 4;

  localparam int MAX_REF_POSTPONE = 8;

  localparam int TMR_MAX = (tREFI > tRFC) ? tREFI : tRFC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT_TRP,
    ST_REF,
    ST_WAIT_TRFC
  } ref_state_e;

endpackage

// File: rtl/lpddr5_refresh_ctrl_if.sv
// Refresh scheduler <-> command scheduler handshake bundle.
// Build option: LPDDR5_REF_POSTPONE_EN (no effect on this file).
interface lpddr5_refresh_ctrl_if;

  logic       pre_req;
  logic       pre_ack;
  logic       ref_req;
  logic       ref_ack;
  logic       ref_busy;
  logic       ref_urgent;
  logic [3:0] pend_cnt;
  logic       ref_ovf;

  modport master (
    output pre_req, ref_req, ref_busy,
    output ref_urgent, pend_cnt, ref_ovf,
    input  pre_ack, ref_ack
  );

  modport slave (
    input  pre_req, ref_req, ref_busy,
    input  ref_urgent, pend_cnt, ref_ovf,
    output pre_ack, ref_ack
  );

endinterface

// File: rtl/lpddr5_delay_timer.sv
// Loadable down-counter; done while the count sits at zero.
// Build option: LPDDR5_REF_POSTPONE_EN (no effect on this file).
module lpddr5_delay_timer #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lpddr5_refresh_ctrl.sv
// All-bank refresh scheduler: interval, owed count, PREA/REF service.
// Build option: LPDDR5_REF_POSTPONE_EN enables refresh postponing.
module lpddr5_refresh_ctrl
  import lpddr5_refresh_ctrl_pkg::*;
#(
  parameter int TREFI        = tREFI,
  parameter int TRFC         = tRFC,
  parameter int TRP          = tRP,
  parameter int MAX_POSTPONE = MAX_REF_POSTPONE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ref_en,
  input  logic banks_idle,
  input  logic sched_idle,
  lpddr5_refresh_ctrl_if.master bus
);

`ifdef LPDDR5_REF_POSTPONE_EN
  localparam int PEND_LIM = MAX_POSTPONE;
`else
  localparam int PEND_LIM = 1;
`endif

  ref_state_e state_q, state_d;
  logic [3:0] pend_q, pend_d;
  logic       ovf_q, ovf_d;
  logic       pre_req_q, ref_req_q;
  logic       busy_q, urg_q;
  logic       urg_d;

  logic             iv_done, tick;
  logic             svc_done, svc_load;
  logic [TMR_W-1:0] svc_val;
  logic             pre_ok, ref_ok;
  logic             at_lim, svc_due;

  lpddr5_delay_timer #(
    .W       (TMR_W),
    .RST_VAL (TMR_W'(TREFI - 1))
  ) u_interval (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tick),
    .en       (ref_en),
    .load_val (TMR_W'(TREFI - 1)),
    .done     (iv_done)
  );

  lpddr5_delay_timer #(
    .W       (TMR_W),
    .RST_VAL ('0)
  ) u_service (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (svc_load),
    .en       (1'b1),
    .load_val (svc_val),
    .done     (svc_done)
  );

  assign tick   = ref_en & iv_done;
  assign pre_ok = pre_req_q & bus.pre_ack;
  assign ref_ok = ref_req_q & bus.ref_ack;
  assign at_lim = (pend_q == 4'(PEND_LIM));

`ifdef LPDDR5_REF_POSTPONE_EN
  assign svc_due = (pend_q != '0 && sched_idle) || at_lim;
`else
  logic unused_cfg;
  assign unused_cfg = &{1'b0, sched_idle, 1'(MAX_POSTPONE)};
  assign svc_due = (pend_q != '0);
`endif

  always_comb begin
    state_d  = state_q;
    svc_load = 1'b0;
    svc_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (svc_due) begin
          state_d = banks_idle ? ST_REF : ST_PRE;
        end
      end
      ST_PRE: begin
        if (pre_ok) begin
          state_d  = ST_WAIT_TRP;
          svc_load = 1'b1;
          svc_val  = TMR_W'(TRP - 1);
        end
      end
      ST_WAIT_TRP: begin
        if (svc_done) state_d = ST_REF;
      end
      ST_REF: begin
        if (ref_ok) begin
          state_d  = ST_WAIT_TRFC;
          svc_load = 1'b1;
          svc_val  = TMR_W'(TRFC - 1);
        end
      end
      ST_WAIT_TRFC: begin
        if (svc_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A tick at the limit is lost and flagged rather than wrapping.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    unique case (1'b1)
      tick && !ref_ok && at_lim:  ovf_d  = 1'b1;
      tick && !ref_ok && !at_lim: pend_d = pend_q + 1'b1;
      !tick && ref_ok:            pend_d = pend_q - 1'b1;
      default: ;
    endcase
  end

`ifdef LPDDR5_REF_POSTPONE_EN
  assign urg_d = (pend_d == 4'(MAX_POSTPONE));
`else
  assign urg_d = (pend_d != '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      pre_req_q <= 1'b0;
      ref_req_q <= 1'b0;
      busy_q    <= 1'b0;
      urg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      pre_req_q <= (state_d == ST_PRE);
      ref_req_q <= (state_d == ST_REF);
      busy_q    <= (state_d != ST_IDLE);
      urg_q     <= urg_d;
    end
  end

  assign bus.pre_req    = pre_req_q;
  assign bus.ref_req    = ref_req_q;
  assign bus.ref_busy   = busy_q;
  assign bus.ref_urgent = urg_q;
  assign bus.pend_cnt   = pend_q;
  assign bus.ref_ovf    = ovf_q;

endmodule
